// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 hex keypad column scanner with press/release debounce
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 100000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_DONE  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cols_q, cols_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic          row_low;
    logic          one_low;
    logic [1:0]    low_idx;
    logic [CW-1:0] cnt_inc;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    always_comb begin
        row_low = ~rows[row_idx_q];
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        // Only a single low row is a usable press; several low rows are ambiguous.
        one_low = 1'b1;
        low_idx = 2'd0;
        case (rows)
            4'b1110: low_idx = 2'd0;
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: one_low = 1'b0;
        endcase

        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            S_SCAN: begin
                if (cnt_q >= SCAN_LAST) begin
                    cnt_d = '0;
                    if (one_low) begin
                        row_idx_d = low_idx;
                        state_d   = S_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DEBOUNCE: begin
                if (cnt_q >= DEB_DONE) begin
                    key_code_d  = key_map(row_idx_q, col_idx_q);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = S_HELD;
                    cnt_d       = '0;
                end else if (row_low) begin
                    cnt_d = cnt_inc;
                end else begin
                    state_d   = S_SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    cnt_d     = '0;
                end
            end
            S_HELD: begin
                if (!row_low) begin
                    state_d = S_RELEASE;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                if (cnt_q >= DEB_DONE) begin
                    key_held_d = 1'b0;
                    state_d    = S_SCAN;
                    col_idx_d  = col_idx_q + 2'd1;
                    cnt_d      = '0;
                end else if (!row_low) begin
                    cnt_d = cnt_inc;
                end else begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end
            end
        endcase

        // Column index only moves while scanning, so the drive stays frozen otherwise.
        cols_d = ~(4'b0001 << col_idx_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cnt_q       <= '0;
            cols_q      <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            cols_q      <= cols_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign cols      = cols_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a modelled key matrix
module tb_keypad_scanner;

    localparam int K1 = 0;
    localparam int K4 = 4;
    localparam int K5 = 5;
    localparam int K9 = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] key_down;

    int          checks = 0;
    int          passes = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;
    logic        prev_valid = 1'b0;
    logic [3:0]  col_seq [5] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};

    keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_down[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            chk(!prev_valid, "valid_back_to_back", prev_valid, 0);
            chk(exp_q.size() != 0, "pulse_expected", key_code, 0);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk(key_code == mon_exp, "pulse_key_code", key_code, mon_exp);
                chk(key_held, "pulse_key_held", key_held, 1);
            end
        end
        prev_valid = key_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col_edge(input logic [3:0] v, input string name);
        int n = 0;
        while (cols == v && n < 100) begin @(negedge clk); n++; end
        while (cols != v && n < 100) begin @(negedge clk); n++; end
        chk(cols == v, name, cols, v);
    endtask

    task automatic wait_held(input logic v, input int lim, input string name);
        int n = 0;
        while (key_held !== v && n < lim) begin @(negedge clk); n++; end
        chk(key_held === v, name, key_held, v);
    endtask

    task automatic wait_drain(input int lim, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin @(negedge clk); n++; end
        chk(exp_q.size() == 0, name, exp_q.size(), 0);
    endtask

    initial begin
        int guard;
        reset    = 1'b0;
        key_down = '0;

        repeat (3) begin
            @(negedge clk);
            chk(cols == 4'b1110, "rst_cols", cols, 4'b1110);
            chk({key_code, key_valid, key_held} == 6'd0, "rst_outputs", {key_code, key_valid, key_held}, 0);
        end
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(4);
            chk(cols == col_seq[k], "scan_step", cols, col_seq[k]);
        end

        wait_col_edge(4'b1101, "t2_col");
        exp_q.push_back(4'h5);
        key_down[K5] = 1'b1;
        cyc(30);
        chk(key_held == 1'b1, "t2_held", key_held, 1);
        chk(key_code == 4'h5, "t2_code", key_code, 5);
        chk(cols == 4'b1101, "t2_frozen", cols, 4'b1101);
        chk(exp_q.size() == 0, "t2_pulse_seen", exp_q.size(), 0);
        key_down[K5] = 1'b0;
        cyc(8);
        chk(key_held == 1'b1, "t2_held_during_release", key_held, 1);
        cyc(1);
        chk(key_held == 1'b0, "t2_released", key_held, 0);
        chk(cols == 4'b1011, "t2_next_col", cols, 4'b1011);

        wait_col_edge(4'b1101, "t3_col");
        key_down[K5] = 1'b1;
        cyc(9);
        key_down[K5] = 1'b0;
        guard = 0;
        while (cols == 4'b1101 && guard < 40) begin @(negedge clk); guard++; end
        chk(cols == 4'b1011, "t3_next_col", cols, 4'b1011);
        chk(key_code == 4'h5, "t3_code_kept", key_code, 5);
        chk(key_held == 1'b0, "t3_not_held", key_held, 0);

        wait_col_edge(4'b1101, "t4_col");
        exp_q.push_back(4'h5);
        key_down[K5] = 1'b1;
        wait_held(1'b1, 40, "t4_held5");
        key_down[K9] = 1'b1;
        cyc(20);
        chk(cols == 4'b1101, "t4_frozen", cols, 4'b1101);
        chk(key_code == 4'h5, "t4_code_still5", key_code, 5);
        exp_q.push_back(4'h9);
        key_down[K5] = 1'b0;
        wait_held(1'b0, 40, "t4_release5");
        wait_drain(60, "t4_detect9");
        cyc(1);
        chk(key_code == 4'h9, "t4_code9", key_code, 9);
        key_down[K9] = 1'b0;
        wait_held(1'b0, 40, "t4_release9");

        key_down[K1] = 1'b1;
        key_down[K4] = 1'b1;
        wait_col_edge(4'b1110, "t5_col0");
        cyc(4);
        chk(cols == 4'b1101, "t5_scan_continues", cols, 4'b1101);
        cyc(16);
        chk(key_held == 1'b0, "t5_not_held", key_held, 0);
        key_down[K1] = 1'b0;
        key_down[K4] = 1'b0;

        wait_col_edge(4'b1101, "t6_col");
        exp_q.push_back(4'h5);
        key_down[K5] = 1'b1;
        wait_held(1'b1, 40, "t6_held");
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk(cols == 4'b1110, "t6_rst_cols", cols, 4'b1110);
        chk({key_code, key_valid, key_held} == 6'd0, "t6_rst_outputs", {key_code, key_valid, key_held}, 0);
        reset = 1'b1;
        exp_q.push_back(4'h5);
        wait_drain(80, "t6_redetect");
        cyc(1);
        chk(key_code == 4'h5, "t6_code", key_code, 5);
        key_down[K5] = 1'b0;
        wait_held(1'b0, 40, "t6_release");

        cyc(5);
        chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
